// File: rtl/machine_control_pkg.sv
// Shared definitions for the M-mode trap/interrupt sequencer: FSM state
// encodings, mcause codes, next-PC source codes and the trap request record.
// Optional feature macro: MACHINE_CONTROL_WFI_EN adds STATE_WFI.
package machine_control_pkg;

    // FSM states; STATE_WFI exists only when WFI support is built in
    typedef enum logic [2:0] {
        STATE_RESET       = 3'd0,
        STATE_OPERATING   = 3'd1,
        STATE_TRAP_TAKEN  = 3'd2,
        STATE_TRAP_RETURN = 3'd3
`ifdef MACHINE_CONTROL_WFI_EN
        ,
        STATE_WFI         = 3'd4
`endif
    } state_t;

    // Interrupt cause codes (i_or_e = 1)
    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    // Exception cause codes (i_or_e = 0)
    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    // Next-PC source selection driven to fetch
    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_MEPC = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    // Result of the priority encoder: winning trap, if any
    typedef struct packed {
        logic       take;
        logic       i_or_e;
        logic [3:0] cause;
    } trap_req_t;

    // True when the winning trap is one of the three misaligned exceptions
    function automatic logic is_misaligned_exc(input trap_req_t req);
        logic mis_code;
        mis_code = (req.cause == CAUSE_INSTR_MISALIGNED) ||
                   (req.cause == CAUSE_LOAD_MISALIGNED)  ||
                   (req.cause == CAUSE_STORE_MISALIGNED);
        return req.take & ~req.i_or_e & mis_code;
    endfunction

endpackage

// File: rtl/machine_control_trap_priority_enc.sv
// Combinational trap priority encoder: picks the highest-priority pending
// interrupt or exception and returns {take, i_or_e, cause}.
// Interrupts are gated by the global mstatus.MIE bit; exceptions are not.
module trap_priority_enc
    import machine_control_pkg::*;
(
    input  logic      mie_i,
    input  logic      meie_i,
    input  logic      mtie_i,
    input  logic      msie_i,
    input  logic      meip_i,
    input  logic      mtip_i,
    input  logic      msip_i,
    input  logic      misaligned_instr_i,
    input  logic      illegal_instr_i,
    input  logic      ebreak_i,
    input  logic      ecall_i,
    input  logic      misaligned_load_i,
    input  logic      misaligned_store_i,
    output trap_req_t req_o
);

    logic irq_mei;
    logic irq_msi;
    logic irq_mti;

    assign irq_mei = mie_i & meie_i & meip_i;
    assign irq_msi = mie_i & msie_i & msip_i;
    assign irq_mti = mie_i & mtie_i & mtip_i;

    // Fixed priority chain: MEI > MSI > MTI > exceptions in architectural order
    always_comb begin
        req_o = '0;
        if (irq_mei) begin
            req_o = '{take: 1'b1, i_or_e: 1'b1, cause: CAUSE_MEI};
        end else if (irq_msi) begin
            req_o = '{take: 1'b1, i_or_e: 1'b1, cause: CAUSE_MSI};
        end else if (irq_mti) begin
            req_o = '{take: 1'b1, i_or_e: 1'b1, cause: CAUSE_MTI};
        end else if (misaligned_instr_i) begin
            req_o = '{take: 1'b1, i_or_e: 1'b0, cause: CAUSE_INSTR_MISALIGNED};
        end else if (illegal_instr_i) begin
            req_o = '{take: 1'b1, i_or_e: 1'b0, cause: CAUSE_ILLEGAL_INSTR};
        end else if (ebreak_i) begin
            req_o = '{take: 1'b1, i_or_e: 1'b0, cause: CAUSE_BREAKPOINT};
        end else if (ecall_i) begin
            req_o = '{take: 1'b1, i_or_e: 1'b0, cause: CAUSE_ECALL_M};
        end else if (misaligned_load_i) begin
            req_o = '{take: 1'b1, i_or_e: 1'b0, cause: CAUSE_LOAD_MISALIGNED};
        end else if (misaligned_store_i) begin
            req_o = '{take: 1'b1, i_or_e: 1'b0, cause: CAUSE_STORE_MISALIGNED};
        end
    end

endmodule

// File: rtl/machine_control.sv
// M-mode trap/interrupt sequencer. Drives the CSR file's trap-side controls
// and selects the next-PC source for fetch. Trap/MRET pulses are produced
// combinationally in the same cycle the instruction reaches the boundary;
// the FSM then spends one cycle redirecting fetch (trap vector or mepc).
// Optional feature macro: MACHINE_CONTROL_WFI_EN adds wfi_in and STATE_WFI.
module machine_control
    import machine_control_pkg::*;
#(
    parameter int BOOT_HOLD_CYCLES = 1  // 1..15 cycles in STATE_RESET
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       instr_valid_in,
    input  logic       stall_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
`ifdef MACHINE_CONTROL_WFI_EN
    input  logic       wfi_in,
`endif
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       misaligned_exc_out
);

    // Last boot-counter value before fetch is released
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_HOLD_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] boot_cnt_q;
    logic [3:0] boot_cnt_d;

    trap_req_t  trap_req;
    logic       decide;

    trap_priority_enc u_prio (
        .mie_i              (mie_in),
        .meie_i             (meie_in),
        .mtie_i             (mtie_in),
        .msie_i             (msie_in),
        .meip_i             (meip_in),
        .mtip_i             (mtip_in),
        .msip_i             (msip_in),
        .misaligned_instr_i (misaligned_instr_in),
        .illegal_instr_i    (illegal_instr_in),
        .ebreak_i           (ebreak_in),
        .ecall_i            (ecall_in),
        .misaligned_load_i  (misaligned_load_in),
        .misaligned_store_i (misaligned_store_in),
        .req_o              (trap_req)
    );

    // A boundary decision is made only for a valid, unstalled instruction
    assign decide = instr_valid_in & ~stall_in;

`ifdef MACHINE_CONTROL_WFI_EN
    // Wake-up ignores the global MIE bit: a pending enabled source is enough
    logic wfi_wake;
    assign wfi_wake = (meip_in & meie_in) | (msip_in & msie_in) | (mtip_in & mtie_in);
`endif

    // Next-state, boot counter and output decode
    always_comb begin
        state_d            = state_q;
        boot_cnt_d         = boot_cnt_q;
        i_or_e_out         = 1'b0;
        cause_out          = 4'd0;
        set_cause_out      = 1'b0;
        set_epc_out        = 1'b0;
        mie_clear_out      = 1'b0;
        mie_set_out        = 1'b0;
        instret_inc_out    = 1'b0;
        pc_src_out         = PC_SRC_NEXT;
        flush_out          = 1'b0;
        misaligned_exc_out = 1'b0;

        unique case (state_q)
            STATE_RESET: begin
                // Boot hold runs regardless of stall; fetch is held at the boot vector
                pc_src_out = PC_SRC_BOOT;
                flush_out  = 1'b1;
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = STATE_OPERATING;
                end
            end

            STATE_OPERATING: begin
                pc_src_out = PC_SRC_NEXT;
                if (decide) begin
                    if (trap_req.take) begin
                        // Trap beats MRET: no mie_set, no retire
                        i_or_e_out         = trap_req.i_or_e;
                        cause_out          = trap_req.cause;
                        set_cause_out      = 1'b1;
                        set_epc_out        = 1'b1;
                        mie_clear_out      = 1'b1;
                        flush_out          = 1'b1;
                        misaligned_exc_out = is_misaligned_exc(trap_req);
                        state_d            = STATE_TRAP_TAKEN;
                    end else if (mret_in) begin
                        mie_set_out     = 1'b1;
                        flush_out       = 1'b1;
                        instret_inc_out = 1'b1;
                        state_d         = STATE_TRAP_RETURN;
                    end else begin
                        instret_inc_out = 1'b1;
`ifdef MACHINE_CONTROL_WFI_EN
                        if (wfi_in) begin
                            state_d = STATE_WFI;
                        end
`endif
                    end
                end
            end

            STATE_TRAP_TAKEN: begin
                // Redirect fetch to the trap vector for one unstalled cycle
                pc_src_out = PC_SRC_TRAP;
                if (!stall_in) begin
                    flush_out = 1'b1;
                    state_d   = STATE_OPERATING;
                end
            end

            STATE_TRAP_RETURN: begin
                // Redirect fetch to mepc for one unstalled cycle
                pc_src_out = PC_SRC_MEPC;
                if (!stall_in) begin
                    flush_out = 1'b1;
                    state_d   = STATE_OPERATING;
                end
            end

`ifdef MACHINE_CONTROL_WFI_EN
            STATE_WFI: begin
                // Keep the pipeline empty until an enabled source is pending
                pc_src_out = PC_SRC_NEXT;
                if (!stall_in) begin
                    flush_out = 1'b1;
                    if (wfi_wake) begin
                        state_d = STATE_OPERATING;
                    end
                end
            end
`endif

            default: begin
                pc_src_out = PC_SRC_BOOT;
                flush_out  = 1'b1;
                state_d    = STATE_RESET;
                boot_cnt_d = 4'd0;
            end
        endcase
    end

    // State and boot counter registers, cleared asynchronously
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= STATE_RESET;
            boot_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

endmodule

// File: tb/tb_machine_control.sv
// Directed table-driven bench for machine_control with BOOT_HOLD_CYCLES=3.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge, before the next rising edge commits the FSM.
module tb_machine_control;

    logic       clk;
    logic       rst_n;
    logic       instr_valid, stall, illegal, mis_i, mis_l, mis_s;
    logic       ecall, ebreak, mret;
    logic       mie, meie, mtie, msie, meip, mtip, msip;
`ifdef MACHINE_CONTROL_WFI_EN
    logic       wfi;
`endif
    logic       i_or_e;
    logic [3:0] cause;
    logic       set_cause, set_epc, mie_clear, mie_set, instret;
    logic [1:0] pc_src;
    logic       flush, mis_exc;

    int n_vec = 0;
    int n_bad = 0;

    machine_control #(.BOOT_HOLD_CYCLES(3)) dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .instr_valid_in      (instr_valid),
        .stall_in            (stall),
        .illegal_instr_in    (illegal),
        .misaligned_instr_in (mis_i),
        .misaligned_load_in  (mis_l),
        .misaligned_store_in (mis_s),
        .ecall_in            (ecall),
        .ebreak_in           (ebreak),
        .mret_in             (mret),
        .mie_in              (mie),
        .meie_in             (meie),
        .mtie_in             (mtie),
        .msie_in             (msie),
        .meip_in             (meip),
        .mtip_in             (mtip),
        .msip_in             (msip),
`ifdef MACHINE_CONTROL_WFI_EN
        .wfi_in              (wfi),
`endif
        .i_or_e_out          (i_or_e),
        .cause_out           (cause),
        .set_cause_out       (set_cause),
        .set_epc_out         (set_epc),
        .mie_clear_out       (mie_clear),
        .mie_set_out         (mie_set),
        .instret_inc_out     (instret),
        .pc_src_out          (pc_src),
        .flush_out           (flush),
        .misaligned_exc_out  (mis_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input bit masks
    localparam logic [15:0] I_VALID = 16'h8000;
    localparam logic [15:0] I_STALL = 16'h4000;
    localparam logic [15:0] I_ILL   = 16'h2000;
    localparam logic [15:0] I_MISI  = 16'h1000;
    localparam logic [15:0] I_MISL  = 16'h0800;
    localparam logic [15:0] I_MISS  = 16'h0400;
    localparam logic [15:0] I_ECALL = 16'h0200;
    localparam logic [15:0] I_EBRK  = 16'h0100;
    localparam logic [15:0] I_MRET  = 16'h0080;
    localparam logic [15:0] I_MIE   = 16'h0040;
    localparam logic [15:0] I_MEIE  = 16'h0020;
    localparam logic [15:0] I_MTIE  = 16'h0010;
    localparam logic [15:0] I_MSIE  = 16'h0008;
    localparam logic [15:0] I_MEIP  = 16'h0004;
    localparam logic [15:0] I_MTIP  = 16'h0002;
    localparam logic [15:0] I_MSIP  = 16'h0001;

    // Output bundle: {i_or_e, cause[3:0], set_cause, set_epc, mie_clear,
    //                 mie_set, instret, pc_src[1:0], flush, misaligned_exc}
    function automatic logic [13:0] ex(input logic ie, input logic [3:0] c,
                                       input logic sc, input logic se, input logic mc,
                                       input logic ms, input logic ii,
                                       input logic [1:0] pc, input logic fl, input logic me);
        return {ie, c, sc, se, mc, ms, ii, pc, fl, me};
    endfunction

    function automatic logic [13:0] trap(input logic ie, input logic [3:0] c, input logic me);
        return ex(ie, c, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, me);
    endfunction

    logic [13:0] E_RST, E_IDLE, E_RETIRE, E_TT, E_TR, E_MRET, E_WFI;

    typedef struct {
        string       name;
        logic [15:0] in;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic [15:0] v);
        instr_valid = v[15]; stall = v[14]; illegal = v[13]; mis_i = v[12];
        mis_l = v[11]; mis_s = v[10]; ecall = v[9]; ebreak = v[8]; mret = v[7];
        mie = v[6]; meie = v[5]; mtie = v[4]; msie = v[3];
        meip = v[2]; mtip = v[1]; msip = v[0];
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {i_or_e, cause, set_cause, set_epc, mie_clear, mie_set, instret,
               pc_src, flush, mis_exc};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive at edge+1, compare at the falling edge, then advance one clock
    task automatic apply(input string name, input logic [15:0] in, input logic [13:0] exp);
        drive(in);
        #4;
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        E_RST    = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        E_IDLE   = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        E_RETIRE = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        E_TT     = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        E_TR     = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        E_MRET   = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
        E_WFI    = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);

        // Boot hold (3 cycles), then the main decision table
        tbl.push_back('{"boot0_stall_ill", I_VALID|I_STALL|I_ILL, E_RST});
        tbl.push_back('{"boot1_mret", I_VALID|I_MRET, E_RST});
        tbl.push_back('{"boot2_valid", I_VALID, E_RST});
        tbl.push_back('{"op_retire", I_VALID, E_RETIRE});
        tbl.push_back('{"op_bubble", 16'h0, E_IDLE});
        tbl.push_back('{"mei_over_illegal", I_VALID|I_MIE|I_MEIE|I_MEIP|I_ILL, trap(1'b1, 4'd11, 1'b0)});
        tbl.push_back('{"tt_after_mei", I_VALID, E_TT});
        tbl.push_back('{"ecall_with_mret", I_VALID|I_ECALL|I_MRET, trap(1'b0, 4'd11, 1'b0)});
        tbl.push_back('{"tt_after_ecall", 16'h0, E_TT});
        tbl.push_back('{"mret_alone", I_VALID|I_MRET, E_MRET});
        tbl.push_back('{"tr_after_mret", 16'h0, E_TR});
        tbl.push_back('{"mie0_mti_load_mis", I_VALID|I_MTIE|I_MTIP|I_MISL, trap(1'b0, 4'd4, 1'b1)});
        tbl.push_back('{"tt_after_load", 16'h0, E_TT});
        tbl.push_back('{"msi_over_mti", I_VALID|I_MIE|I_MSIE|I_MSIP|I_MTIE|I_MTIP, trap(1'b1, 4'd3, 1'b0)});
        tbl.push_back('{"tt_stalled", I_VALID|I_STALL, E_IDLE ^ 14'b00000000000001 ^ 14'b00000000000001 ^ 14'b00000000000100});
        tbl.push_back('{"tt_after_msi", 16'h0, E_TT});
        tbl.push_back('{"mti_over_ebreak", I_VALID|I_MIE|I_MTIE|I_MTIP|I_EBRK, trap(1'b1, 4'd7, 1'b0)});
        tbl.push_back('{"tt_ignores_inputs", I_VALID|I_EBRK|I_ILL, E_TT});
        tbl.push_back('{"imis_over_illegal", I_VALID|I_MISI|I_ILL, trap(1'b0, 4'd0, 1'b1)});
        tbl.push_back('{"tt_after_imis", 16'h0, E_TT});
        tbl.push_back('{"illegal_over_ebreak", I_VALID|I_ILL|I_EBRK|I_ECALL, trap(1'b0, 4'd2, 1'b0)});
        tbl.push_back('{"tt_after_ill", 16'h0, E_TT});
        tbl.push_back('{"ebreak_over_ecall", I_VALID|I_EBRK|I_ECALL|I_MISS, trap(1'b0, 4'd3, 1'b0)});
        tbl.push_back('{"tt_after_ebrk", 16'h0, E_TT});
        tbl.push_back('{"store_mis", I_VALID|I_MISS, trap(1'b0, 4'd6, 1'b1)});
        tbl.push_back('{"tt_after_store", 16'h0, E_TT});
        tbl.push_back('{"mie0_no_irq", I_VALID|I_MEIE|I_MEIP|I_MSIE|I_MSIP, E_RETIRE});
        tbl.push_back('{"ecall_over_load", I_VALID|I_ECALL|I_MISL, trap(1'b0, 4'd11, 1'b0)});
        tbl.push_back('{"tt_after_ecall2", 16'h0, E_TT});
        tbl.push_back('{"irq_needs_valid", I_MIE|I_MEIE|I_MEIP, E_IDLE});

        // Reset state, independent of stall and events
        drive(16'h0);
        rst_n = 1'b0;
        #2;
        check("reset_quiet", E_RST);
        drive(I_VALID|I_STALL|I_ILL|I_MRET|I_MIE|I_MEIE|I_MEIP);
        #1;
        check("reset_busy_inputs", E_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i].name, tbl[i].in, tbl[i].exp);

        // Trap request held off by 4 stalled cycles, taken on the first free one
        for (int k = 0; k < 4; k++) apply("stall_trap_held", I_VALID|I_STALL|I_ILL, E_IDLE);
        apply("stall_trap_taken", I_VALID|I_ILL, trap(1'b0, 4'd2, 1'b0));

        // Asynchronous reset while in STATE_TRAP_TAKEN
        drive(I_VALID);
        #1;
        check("tt_before_reset", E_TT);
        rst_n = 1'b0;
        #1;
        check("reset_mid_tt", E_RST);
        @(posedge clk);
        #1;
        check("reset_held_edge", E_RST);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) apply("reboot_hold", I_VALID, E_RST);
        apply("reboot_operating", I_VALID, E_RETIRE);

`ifdef MACHINE_CONTROL_WFI_EN
        // WFI entry, MIE-independent wake-up on an enabled pending source
        wfi = 1'b1;
        apply("wfi_retire", I_VALID, E_RETIRE);
        wfi = 1'b0;
        apply("wfi_sleep", I_VALID, E_WFI);
        apply("wfi_tip_not_enabled", I_MTIP, E_WFI);
        apply("wfi_wake_mti", I_MTIP|I_MTIE, E_WFI);
        apply("wfi_resumed", I_VALID, E_RETIRE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
